// File: rtl/ddr3_axi_tester_pkg.sv
// Shared types and constants for the DDR3 AXI tester.
package ddr3_axi_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] value);
    lfsr_step = {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/ddr3_axi_tester_pattern.sv
// Beat data generator shared by the write and read phases.
// load_i restarts the sequence at the first beat of a phase, step_i advances
// it by one beat. Beats are contiguous across bursts, so one load per phase
// is enough.
// Build option DDR3_AXI_TESTER_LFSR_EN: defined selects a seeded 32-bit
// Galois LFSR; undefined selects beat_address ^ seed.
module ddr3_axi_tester_pattern
  import ddr3_axi_tester_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] seed_i,
  output logic [31:0] data_o
);

`ifdef DDR3_AXI_TESTER_LFSR_EN
  logic [31:0] lfsr_r;

  // LFSR state: an all-zero seed would lock up, so it is replaced by 1.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      lfsr_r <= 32'h0000_0001;
    end else if (load_i) begin
      lfsr_r <= (seed_i == 32'h0000_0000) ? 32'h0000_0001 : seed_i;
    end else if (step_i) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  assign data_o = lfsr_r;
`else
  logic [31:0] addr_r;
  logic [31:0] seed_r;

  // Track the current beat address; it wraps silently at 32 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_r <= 32'h0000_0000;
      seed_r <= 32'h0000_0000;
    end else if (load_i) begin
      addr_r <= addr_i;
      seed_r <= seed_i;
    end else if (step_i) begin
      addr_r <= addr_r + 32'd4;
    end
  end

  assign data_o = addr_r ^ seed_r;
`endif

endmodule

// File: rtl/ddr3_axi_tester.sv
// AXI4 write/read-back memory tester: writes a pattern over a contiguous
// region as INCR bursts, reads it back and compares every beat.
// One transaction is outstanding at a time. Build option
// DDR3_AXI_TESTER_LFSR_EN selects the LFSR data pattern (see pattern block).
module ddr3_axi_tester
  import ddr3_axi_tester_pkg::*;
#(
  parameter int         BURST_LEN = 8,
  parameter logic [3:0] AXI_ID    = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] num_bursts_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] error_count_o,
  output logic [31:0] first_err_addr_o,
  output logic        outport_awvalid_o,
  output logic [31:0] outport_awaddr_o,
  output logic [3:0]  outport_awid_o,
  output logic [7:0]  outport_awlen_o,
  output logic [1:0]  outport_awburst_o,
  output logic        outport_wvalid_o,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  output logic        outport_wlast_o,
  output logic        outport_bready_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  output logic        outport_rready_o,
  input  logic        outport_awready_i,
  input  logic        outport_wready_i,
  input  logic        outport_bvalid_i,
  input  logic [1:0]  outport_bresp_i,
  input  logic [3:0]  outport_bid_i,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i
);

  // Aligning the base to a whole burst keeps every burst inside one 4 KB page.
  localparam int          ALIGN_BITS  = $clog2(BURST_LEN * 4);
  localparam logic [31:0] ALIGN_MASK  = ~((32'd1 << ALIGN_BITS) - 32'd1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);

  state_t      state_r, state_next_s;
  logic [31:0] base_r, burst_addr_r, seed_r;
  logic [15:0] num_bursts_r, burst_cnt_r;
  logic [7:0]  beat_cnt_r;
  logic [15:0] err_cnt_r;
  logic [31:0] first_err_r;
  logic        awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
  logic        busy_r, done_r, pass_r;

  logic        start_acc_s, last_beat_s, last_burst_s;
  logic        w_fire_s, b_fire_s, r_fire_s;
  logic        err_hit_s;
  logic [31:0] err_addr_s, beat_addr_s, base_aligned_s;
  logic        pat_load_s, pat_step_s;
  logic [31:0] pat_addr_s, pat_seed_s, pat_data_s;

  assign start_acc_s    = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign base_aligned_s = base_addr_i & ALIGN_MASK;
  assign last_beat_s    = (beat_cnt_r == LAST_BEAT);
  assign last_burst_s   = (burst_cnt_r == (num_bursts_r - 16'd1));
  assign beat_addr_s    = burst_addr_r + {22'd0, beat_cnt_r, 2'b00};
  assign w_fire_s       = wvalid_r && outport_wready_i;
  assign b_fire_s       = bready_r && outport_bvalid_i;
  assign r_fire_s       = rready_r && outport_rvalid_i;

  // The generator restarts at the base for each phase and steps per beat.
  assign pat_load_s = start_acc_s || (b_fire_s && last_burst_s);
  assign pat_step_s = w_fire_s || r_fire_s;
  assign pat_addr_s = start_acc_s ? base_aligned_s : base_r;
  assign pat_seed_s = start_acc_s ? seed_i : seed_r;

  ddr3_axi_tester_pattern u_pattern (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (pat_load_s),
    .step_i  (pat_step_s),
    .addr_i  (pat_addr_s),
    .seed_i  (pat_seed_s),
    .data_o  (pat_data_s)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the beat and burst counters decide where bursts end.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) begin
          state_next_s = (num_bursts_i == 16'd0) ? ST_DONE : ST_WR_ADDR;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_WR_ADDR: begin
        if (outport_awready_i) state_next_s = ST_WR_DATA;
        else                   state_next_s = ST_WR_ADDR;
      end
      ST_WR_DATA: begin
        if (w_fire_s && last_beat_s) state_next_s = ST_WR_RESP;
        else                         state_next_s = ST_WR_DATA;
      end
      ST_WR_RESP: begin
        if (b_fire_s) state_next_s = last_burst_s ? ST_RD_ADDR : ST_WR_ADDR;
        else          state_next_s = ST_WR_RESP;
      end
      ST_RD_ADDR: begin
        if (outport_arready_i) state_next_s = ST_RD_DATA;
        else                   state_next_s = ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        if (r_fire_s && last_beat_s) state_next_s = last_burst_s ? ST_DONE : ST_RD_ADDR;
        else                         state_next_s = ST_RD_DATA;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Region, burst and beat bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      base_r       <= 32'h0000_0000;
      burst_addr_r <= 32'h0000_0000;
      seed_r       <= 32'h0000_0000;
      num_bursts_r <= 16'd0;
      burst_cnt_r  <= 16'd0;
      beat_cnt_r   <= 8'd0;
    end else if (start_acc_s) begin
      base_r       <= base_aligned_s;
      burst_addr_r <= base_aligned_s;
      seed_r       <= seed_i;
      num_bursts_r <= num_bursts_i;
      burst_cnt_r  <= 16'd0;
      beat_cnt_r   <= 8'd0;
    end else begin
      if (w_fire_s || r_fire_s) begin
        beat_cnt_r <= last_beat_s ? 8'd0 : (beat_cnt_r + 8'd1);
      end
      if (b_fire_s || (r_fire_s && last_beat_s)) begin
        if (last_burst_s) begin
          burst_cnt_r  <= 16'd0;
          burst_addr_r <= base_r;
        end else begin
          burst_cnt_r  <= burst_cnt_r + 16'd1;
          burst_addr_r <= burst_addr_r + BURST_BYTES;
        end
      end
    end
  end

  // Classify each response: a failing beat counts once whatever went wrong.
  always_comb begin
    err_hit_s  = 1'b0;
    err_addr_s = 32'h0000_0000;
    if (b_fire_s) begin
      err_hit_s  = (outport_bresp_i != AXI_RESP_OKAY) || (outport_bid_i != AXI_ID);
      err_addr_s = burst_addr_r;
    end else if (r_fire_s) begin
      err_hit_s  = (outport_rdata_i != pat_data_s) ||
                   (outport_rresp_i != AXI_RESP_OKAY) ||
                   (outport_rid_i != AXI_ID) ||
                   (outport_rlast_i != last_beat_s);
      err_addr_s = beat_addr_s;
    end else begin
      err_hit_s  = 1'b0;
      err_addr_s = 32'h0000_0000;
    end
  end

  // Saturating error counter and first-failure address capture.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_cnt_r   <= 16'd0;
      first_err_r <= 32'h0000_0000;
    end else if (start_acc_s) begin
      err_cnt_r   <= 16'd0;
      first_err_r <= 32'h0000_0000;
    end else if (err_hit_s) begin
      if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
      if (err_cnt_r == 16'd0)    first_err_r <= err_addr_s;
    end
  end

  // Handshake and status outputs, registered from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      awvalid_r <= (state_next_s == ST_WR_ADDR);
      wvalid_r  <= (state_next_s == ST_WR_DATA);
      bready_r  <= (state_next_s == ST_WR_RESP);
      arvalid_r <= (state_next_s == ST_RD_ADDR);
      rready_r  <= (state_next_s == ST_RD_DATA);
      busy_r    <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE);
      done_r    <= (state_next_s == ST_DONE);
      pass_r    <= (state_next_s == ST_DONE) && !err_hit_s &&
                   (start_acc_s || (err_cnt_r == 16'd0));
    end
  end

  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign pass_o            = pass_r;
  assign error_count_o     = err_cnt_r;
  assign first_err_addr_o  = first_err_r;

  assign outport_awvalid_o = awvalid_r;
  assign outport_awaddr_o  = burst_addr_r;
  assign outport_awid_o    = AXI_ID;
  assign outport_awlen_o   = LAST_BEAT;
  assign outport_awburst_o = AXI_BURST_INCR;
  assign outport_wvalid_o  = wvalid_r;
  assign outport_wdata_o   = pat_data_s;
  assign outport_wstrb_o   = 4'hF;
  assign outport_wlast_o   = wvalid_r && last_beat_s;
  assign outport_bready_o  = bready_r;
  assign outport_arvalid_o = arvalid_r;
  assign outport_araddr_o  = burst_addr_r;
  assign outport_arid_o    = AXI_ID;
  assign outport_arlen_o   = LAST_BEAT;
  assign outport_arburst_o = AXI_BURST_INCR;
  assign outport_rready_o  = rready_r;

endmodule

// File: tb/tb_ddr3_axi_tester.sv
// Directed bench for ddr3_axi_tester with a small AXI slave memory model.
module tb_ddr3_axi_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [15:0] num_bursts = 16'h0;
  logic [31:0] seed = 32'h0;

  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [31:0] first_err_addr;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  awid, arid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst;

  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'h0;
  logic [3:0]  bid = 4'd0, rid = 4'd0;

  ddr3_axi_tester dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .base_addr_i(base_addr),
    .num_bursts_i(num_bursts), .seed_i(seed), .busy_o(busy), .done_o(done),
    .pass_o(pass), .error_count_o(error_count), .first_err_addr_o(first_err_addr),
    .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awid_o(awid),
    .outport_awlen_o(awlen), .outport_awburst_o(awburst),
    .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
    .outport_wlast_o(wlast), .outport_bready_o(bready),
    .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arid_o(arid),
    .outport_arlen_o(arlen), .outport_arburst_o(arburst), .outport_rready_o(rready),
    .outport_awready_i(awready), .outport_wready_i(wready), .outport_bvalid_i(bvalid),
    .outport_bresp_i(bresp), .outport_bid_i(bid), .outport_arready_i(arready),
    .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
    .outport_rid_i(rid), .outport_rlast_i(rlast)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Slave model configuration and observations.
  bit          stall_en;
  logic [31:0] corrupt_addr, rresp_err_addr;
  int          bresp_err_burst;
  int          aw_count, ar_count, w_count, r_count, wb_count, prot_err;
  logic [31:0] first_awaddr, last_araddr;
  logic [31:0] mem [0:1023];

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; int rdy; } rbeat_t;
  rbeat_t      r_q[$];
  rbeat_t      rb;
  logic [1:0]  b_q[$];
  int          cyc = 0;
  int          w_open, w_beat;
  bit          b_fire, r_fire, aw_wait, w_wait, ar_wait;
  logic [31:0] aw_hold, ar_hold, w_hold, wr_ptr, a;
  logic        wl_hold;

  function automatic int midx(input logic [31:0] addr);
    return int'(addr[11:2]);
  endfunction

  // AXI slave: decides everything at the falling edge; handshakes fire at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0;
      bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0; bresp = 2'b00; rresp = 2'b00;
      b_q.delete(); r_q.delete();
      b_fire = 0; r_fire = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; w_open = 0; w_beat = 0;
    end else begin
      if (b_fire) begin bvalid = 1'b0; void'(b_q.pop_front()); end
      if (r_fire) begin rvalid = 1'b0; void'(r_q.pop_front()); r_count++; end
      if (aw_wait && (!awvalid || awaddr !== aw_hold)) prot_err++;
      if (ar_wait && (!arvalid || araddr !== ar_hold)) prot_err++;
      if (w_wait && (!wvalid || wdata !== w_hold || wlast !== wl_hold)) prot_err++;
      awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wvalid && w_open == 0) prot_err++;
      if (wvalid && wready) begin
        mem[midx(wr_ptr)] = wdata;
        wr_ptr = wr_ptr + 32'd4;
        w_count++;
        if (wstrb !== 4'hF) prot_err++;
        if (wlast !== (w_beat == 7)) prot_err++;
        if (w_beat == 7) begin
          w_beat = 0; w_open--;
          b_q.push_back((wb_count == bresp_err_burst) ? 2'b10 : 2'b00);
          wb_count++;
        end else begin
          w_beat++;
        end
      end
      if (awvalid && awready) begin
        if (aw_count == 0) first_awaddr = awaddr;
        if (awlen !== 8'd7 || awburst !== 2'b01 || awid !== 4'd0) prot_err++;
        wr_ptr = awaddr; w_open++; aw_count++;
      end
      if (arvalid && arready) begin
        last_araddr = araddr; ar_count++;
        if (arlen !== 8'd7 || arburst !== 2'b01 || arid !== 4'd0) prot_err++;
        for (int i = 0; i < 8; i++) begin
          a = araddr + 32'(4 * i);
          rb.data = mem[midx(a)] ^ ((a == corrupt_addr) ? 32'h1 : 32'h0);
          rb.resp = (a == rresp_err_addr) ? 2'b10 : 2'b00;
          rb.last = (i == 7);
          rb.rdy  = cyc + 3;
          r_q.push_back(rb);
        end
      end
      aw_wait = awvalid && !awready; aw_hold = awaddr;
      ar_wait = arvalid && !arready; ar_hold = araddr;
      w_wait  = wvalid && !wready;   w_hold = wdata; wl_hold = wlast;
      if (!bvalid && b_q.size() != 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
        bvalid = 1'b1; bresp = b_q[0];
      end
      if (!rvalid && r_q.size() != 0 && r_q[0].rdy <= cyc && (!stall_en || $urandom_range(0, 1) == 1)) begin
        rvalid = 1'b1; rdata = r_q[0].data; rresp = r_q[0].resp; rlast = r_q[0].last;
      end
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
    end
  end

  task automatic clear_model();
    stall_en = 0; corrupt_addr = 32'hFFFF_FFFF; rresp_err_addr = 32'hFFFF_FFFF;
    bresp_err_burst = -1; aw_count = 0; ar_count = 0; w_count = 0; r_count = 0;
    wb_count = 0; prot_err = 0; first_awaddr = 32'h0; last_araddr = 32'h0;
  endtask

  // Pulse start for one cycle; returns at the falling edge after it was sampled.
  task automatic start_run(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    base_addr = b; num_bursts = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin timed_out = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, done, pass} !== 8'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass});
    end
    n_checks++;
    if (error_count !== 16'd0 || first_err_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_err: got %h/%h expected 0000/00000000", error_count, first_err_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    clear_model();
    start_run(32'h1000, 16'd4, 32'hA5A5_A5A5);
    n_checks++;
    if ({awvalid, busy, done} !== 3'b110) begin
      n_fail++; $display("FAIL basic_start: got awvalid/busy/done=%b expected 110", {awvalid, busy, done});
    end
    wait_done(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL basic_timeout: got timeout expected done"); end
    n_checks++; if (pass !== 1'b1 || error_count !== 16'd0) begin
      n_fail++; $display("FAIL basic_pass: got pass=%b err=%0d expected pass=1 err=0", pass, error_count); end
    n_checks++; if (w_count != 32 || r_count != 32) begin
      n_fail++; $display("FAIL basic_beats: got w=%0d r=%0d expected 32/32", w_count, r_count); end
    n_checks++; if (last_araddr !== 32'h1060 || first_awaddr !== 32'h1000) begin
      n_fail++; $display("FAIL basic_addr: got last_ar=%h first_aw=%h expected 00001060/00001000", last_araddr, first_awaddr); end
    n_checks++; if (mem[midx(32'h1024)] !== 32'hA5A5_B581) begin
      n_fail++; $display("FAIL basic_data: got %h expected a5a5b581", mem[midx(32'h1024)]); end
    n_checks++; if (prot_err != 0) begin n_fail++; $display("FAIL basic_protocol: got %0d expected 0", prot_err); end
  endtask

  task automatic test_corrupt();
    bit to;
    clear_model();
    corrupt_addr = 32'h1024;
    start_run(32'h1000, 16'd4, 32'hA5A5_A5A5);
    wait_done(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL corrupt_timeout: got timeout expected done"); end
    n_checks++; if (error_count !== 16'd1 || first_err_addr !== 32'h1024 || pass !== 1'b0) begin
      n_fail++; $display("FAIL corrupt_result: got err=%0d addr=%h pass=%b expected 1/00001024/0", error_count, first_err_addr, pass); end
  endtask

  task automatic test_stalls();
    bit to;
    clear_model();
    stall_en = 1;
    start_run(32'h1000, 16'd4, 32'hA5A5_A5A5);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL stall_done_clear: got %b expected 0", done); end
    repeat (5) @(negedge clk);
    start_run(32'h2000, 16'd1, 32'h0);
    wait_done(4000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL stall_timeout: got timeout expected done"); end
    n_checks++; if (pass !== 1'b1 || error_count !== 16'd0 || r_count != 32 || w_count != 32) begin
      n_fail++; $display("FAIL stall_result: got pass=%b err=%0d r=%0d w=%0d expected 1/0/32/32", pass, error_count, r_count, w_count); end
    n_checks++; if (last_araddr !== 32'h1060) begin n_fail++; $display("FAIL stall_araddr: got %h expected 00001060", last_araddr); end
    n_checks++; if (prot_err != 0) begin n_fail++; $display("FAIL stall_protocol: got %0d expected 0", prot_err); end
  endtask

  task automatic test_resp_err();
    bit to;
    clear_model();
    bresp_err_burst = 2; rresp_err_addr = 32'h1064;
    start_run(32'h1000, 16'd4, 32'hA5A5_A5A5);
    wait_done(2000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL resp_timeout: got timeout expected done"); end
    n_checks++; if (error_count !== 16'd2 || first_err_addr !== 32'h1040 || pass !== 1'b0) begin
      n_fail++; $display("FAIL resp_result: got err=%0d addr=%h pass=%b expected 2/00001040/0", error_count, first_err_addr, pass); end
  endtask

  task automatic test_zero_bursts();
    clear_model();
    start_run(32'h1000, 16'd0, 32'h1234_5678);
    n_checks++; if ({done, pass, busy, awvalid} !== 4'b1100 || error_count !== 16'd0) begin
      n_fail++; $display("FAIL zero_done: got done/pass/busy/awvalid=%b err=%0d expected 1100/0", {done, pass, busy, awvalid}, error_count); end
    repeat (5) @(negedge clk);
    n_checks++; if (aw_count != 0 || ar_count != 0) begin
      n_fail++; $display("FAIL zero_traffic: got aw=%0d ar=%0d expected 0/0", aw_count, ar_count); end
  endtask

  task automatic test_align();
    bit to;
    clear_model();
    start_run(32'h1007, 16'd1, 32'h0F0F_0F0F);
    wait_done(1000, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL align_timeout: got timeout expected done"); end
    n_checks++; if (first_awaddr !== 32'h1000 || pass !== 1'b1 || w_count != 8) begin
      n_fail++; $display("FAIL align_result: got aw=%h pass=%b w=%0d expected 00001000/1/8", first_awaddr, pass, w_count); end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit seen;
    clear_model();
    seen = 1'b0;
    start_run(32'h1000, 16'd4, 32'hA5A5_A5A5);
    for (int i = 0; i < 1000; i++) begin
      if (rready) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midrst_reach: got no read phase expected rready=1"); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({awvalid, wvalid, arvalid, bready, rready, busy} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_outputs: got %b expected 000000", {awvalid, wvalid, arvalid, bready, rready, busy}); end
    rst_n = 1'b1;
    @(negedge clk);
    clear_model();
    start_run(32'h1000, 16'd4, 32'hA5A5_A5A5);
    wait_done(2000, to);
    n_checks++; if (to || pass !== 1'b1 || error_count !== 16'd0 || r_count != 32) begin
      n_fail++; $display("FAIL midrst_rerun: got to=%0d pass=%b err=%0d r=%0d expected 0/1/0/32", to, pass, error_count, r_count); end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic();
    test_corrupt();
    test_stalls();
    test_resp_err();
    test_zero_bursts();
    test_align();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_axi_tester.md
Name: ddr3_axi_tester

Overview:
AXI4 initiator that exercises the DDR3 AXI controller. It writes a deterministic data pattern over a contiguous region as INCR bursts, reads the region back, and compares every beat. It reports done, pass/fail, an error count and the first failing address. It sits in the ddr_test top and drives the controller's inport_* AXI slave port.

Parameters:
BURST_LEN, 8, beats per burst; power of two, 1..256; awlen/arlen = BURST_LEN-1
AXI_ID, 0, 4-bit ID driven on awid/arid and expected on bid/rid

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous reset, active low
start_i  in  1  start pulse; sampled only in IDLE/DONE
base_addr_i  in  32  region base; low log2(BURST_LEN*4) bits forced to 0
num_bursts_i  in  16  bursts to write then read
seed_i  in  32  pattern seed
busy_o  out  1  test in progress
done_o  out  1  test finished; held until next accepted start
pass_o  out  1  valid while done_o=1; 1 = error_count_o==0
error_count_o  out  16  mismatches plus response errors; saturates at 0xFFFF
first_err_addr_o  out  32  byte address of the first failing beat/burst
outport_awvalid_o/awaddr_o[31:0]/awid_o[3:0]/awlen_o[7:0]/awburst_o[1:0]  out  AW channel
outport_wvalid_o/wdata_o[31:0]/wstrb_o[3:0]/wlast_o  out  W channel
outport_bready_o  out  1  B channel ready
outport_arvalid_o/araddr_o[31:0]/arid_o[3:0]/arlen_o[7:0]/arburst_o[1:0]  out  AR channel
outport_rready_o  out  1  R channel ready
outport_awready_i, wready_i, bvalid_i, bresp_i[1:0], bid_i[3:0]  in  write handshakes/response
outport_arready_i, rvalid_i, rdata_i[31:0], rresp_i[1:0], rid_i[3:0], rlast_i  in  read handshakes/data

Behaviour:
- Reset (rst_n_i=0 at a clock edge): state IDLE; all valids 0; bready/rready 0; busy/done/pass 0; error_count and first_err_addr 0.
- Reset mid-test: valids drop on the next edge, which violates AXI. The controller must be reset in the same cycle.
- FSM: IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> (more bursts ? WR_ADDR : RD_ADDR) -> RD_DATA -> (more ? RD_ADDR : DONE). DONE -> WR_ADDR on start_i.
- start_i in IDLE/DONE at cycle N: counters and pattern reload, errors clear, done_o clears, busy_o=1, awvalid_o=1 at N+1. start_i while busy is ignored.
- num_bursts_i=0: go straight to DONE at N+1 with pass_o=1.
- One transaction outstanding at a time. AW/AR valid is held with constant payload until ready. W beats start only after the AW handshake.
- Burst k uses address base + k*BURST_LEN*4; awburst/arburst=2'b01 (INCR); wstrb=4'hF; wlast on beat BURST_LEN-1.
- Beat data = pattern(beat address, seed). The read phase regenerates the identical sequence.
- WR_RESP: bready=1. Error if bresp!=2'b00 or bid!=AXI_ID; the recorded address is the burst address.
- RD_DATA: rready=1; each rvalid beat is compared. Error if data, rresp, or rid differs. Error also if rlast disagrees with the internal beat counter; the counter is authoritative and ends the burst.
- first_err_addr_o latches only on the first error. Each failing beat adds 1 (a response error on a mismatching beat counts once).
- Address arithmetic is 32-bit and wraps silently. The region must not cross 4 KB per burst; the alignment mask guarantees this.

Optional Feature:
DDR3_AXI_TESTER_LFSR_EN
- Defined: data is a 32-bit Galois LFSR (taps 32,22,2,1) loaded with seed_i (0 replaced by 32'h1) and stepped once per beat. It reloads from the seed at the start of the read phase.
- Undefined: data = beat_address ^ seed_i.

Decomposition:
- Package ddr3_axi_tester_pkg: FSM state encodings; AXI_BURST_INCR=2'b01; AXI_RESP_OKAY=2'b00; LFSR tap constant.
- Sub-module ddr3_axi_tester_pattern (load, step, addr, seed -> data) holds the macro-selected generator. It is shared by the write and read paths via a reload at the phase change.

Test Plan:
- Ideal slave model (zero-wait ready, 3-cycle read latency), base 0x1000, 4 bursts, seed 0xA5A5A5A5, BURST_LEN=8 -> 32 writes, 32 reads, done=1, pass=1, error_count=0; last araddr=0x1060.
- Slave corrupts beat 0x1024 (flip bit 0) -> error_count=1, first_err_addr=0x1024, pass=0.
- Random stalls on all ready/valid (50%) -> payload stable while valid && !ready; same result as scenario 1.
- bresp=2'b10 on burst 2 and rresp=2'b10 on one beat -> error_count=2; first_err_addr=0x1040.
- base 0x1007 -> first awaddr 0x1000; num_bursts=0 -> done one cycle after start, pass=1, no AXI traffic.
- Reset asserted during RD_DATA -> next cycle all valids 0, busy=0; a subsequent start reruns cleanly.
